// File: rtl/ddr_wr_pkg.sv
// Shared constants and FSM state type for the DDR write packer.
package ddr_wr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StReq,
    StDrain,
    StResp
  } wr_state_e;

endpackage

// File: rtl/ddr_wr_seg_buf.sv
// Segment buffer: FIFO of packed wide words with push/pop/count.
module ddr_wr_seg_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 288
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  // Guards keep the pointers sane even if the caller misbehaves.
  assign do_push = push_i && (count_q != (PtrW + 1)'(Depth));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ddr_wr_packer.sv
// Packs narrow slave write bursts into native-width DDR write segments of up to MAX_WORDS words.
module ddr_wr_packer
  import ddr_wr_pkg::*;
#(
  parameter int unsigned SLV_DW    = 32,
  parameter int unsigned MEM_DW    = 256,
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_W-1:0]              SLV_WR_ADDR_ID,
  input  logic [ADDR_W-1:0]            SLV_WR_ADDR,
  input  logic [7:0]                   SLV_WR_ADDR_LEN,
  input  logic [1:0]                   SLV_WR_ADDR_BURST,
  input  logic                         SLV_WR_ADDR_VALID,
  output logic                         SLV_WR_ADDR_READY,
  input  logic [SLV_DW-1:0]            SLV_WR_DATA,
  input  logic [SLV_DW/8-1:0]          SLV_WR_STRB,
  input  logic                         SLV_WR_DATA_LAST,
  input  logic                         SLV_WR_DATA_VALID,
  output logic                         SLV_WR_DATA_READY,
  output logic [ID_W-1:0]              SLV_WR_BACK_ID,
  output logic [1:0]                   SLV_WR_BACK_RESP,
  output logic                         SLV_WR_BACK_VALID,
  input  logic                         SLV_WR_BACK_READY,
  output logic [ADDR_W-1:0]            WRITE_ADDR,
  output logic [$clog2(MAX_WORDS)-1:0] WRITE_LEN,
  output logic [ID_W-1:0]              WRITE_ID,
  output logic                         WRITE_ADDR_VALID,
  input  logic                         WRITE_ADDR_READY,
  output logic [MEM_DW-1:0]            WRITE_DATA,
  output logic [MEM_DW/8-1:0]          WRITE_STRB,
  input  logic                         WRITE_DATA_READY,
  output logic                         WRITE_DATA_LAST
);

  localparam int unsigned RATIO  = MEM_DW / SLV_DW;
  localparam int unsigned LANE_W = $clog2(RATIO);
  localparam int unsigned LEN_W  = $clog2(MAX_WORDS);
  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned SLV_SW = SLV_DW / 8;
  localparam int unsigned MEM_SW = MEM_DW / 8;
  localparam int unsigned BUF_W  = MEM_DW + MEM_SW;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(RATIO - 1);

  wr_state_e         state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q, seg_addr_q;
  logic [7:0]        len_q, beat_q;
  logic              incr_q, err_q, done_q;
  logic [MEM_DW-1:0] word_data_q, word_data_nx;
  logic [MEM_SW-1:0] word_strb_q, word_strb_nx;

  logic              addr_fire, beat_fire, is_final, word_close, seg_full, pop, last_pop;
  logic [LANE_W-1:0] lane;
  logic [CNT_W-1:0]  buf_cnt;
  logic [BUF_W-1:0]  buf_head;

  assign addr_fire  = SLV_WR_ADDR_VALID && SLV_WR_ADDR_READY;
  assign beat_fire  = SLV_WR_DATA_VALID && SLV_WR_DATA_READY;
  assign pop        = (state_q == StDrain) && WRITE_DATA_READY && !rst;
  assign lane       = addr_q[LANE_W-1:0];
  assign is_final   = (beat_q == len_q);
  assign word_close = beat_fire && incr_q && ((lane == LANE_W'(RATIO - 1)) || is_final);
  assign seg_full   = (buf_cnt == CNT_W'(MAX_WORDS - 1));
  assign last_pop   = pop && (buf_cnt == CNT_W'(1));

  always_comb begin
    word_data_nx = word_data_q;
    word_strb_nx = word_strb_q;
    word_data_nx[lane*SLV_DW +: SLV_DW] = SLV_WR_DATA;
    word_strb_nx[lane*SLV_SW +: SLV_SW] = SLV_WR_STRB;
  end

  ddr_wr_seg_buf #(
    .Depth(MAX_WORDS),
    .Width(BUF_W)
  ) u_seg_buf (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (word_close),
    .data_i ({word_strb_nx, word_data_nx}),
    .pop_i  (pop),
    .head_o (buf_head),
    .count_o(buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (addr_fire) state_d = StFill;
      StFill: begin
        if (beat_fire) begin
          if (!incr_q) begin
            if (is_final) state_d = StResp;
          end else if (word_close && (is_final || seg_full)) begin
            state_d = StReq;
          end
        end
      end
      StReq:   if (WRITE_ADDR_READY) state_d = StDrain;
      StDrain: if (last_pop) state_d = done_q ? StResp : StFill;
      StResp:  if (SLV_WR_BACK_READY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced low while rst is high so nothing leaks out of a half-reset state.
  always_comb begin
    SLV_WR_ADDR_READY = 1'b0;
    SLV_WR_DATA_READY = 1'b0;
    SLV_WR_BACK_ID    = '0;
    SLV_WR_BACK_RESP  = RESP_OKAY;
    SLV_WR_BACK_VALID = 1'b0;
    WRITE_ADDR        = '0;
    WRITE_LEN         = '0;
    WRITE_ID          = '0;
    WRITE_ADDR_VALID  = 1'b0;
    WRITE_DATA        = '0;
    WRITE_STRB        = '0;
    WRITE_DATA_LAST   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: SLV_WR_ADDR_READY = 1'b1;
        StFill: SLV_WR_DATA_READY = 1'b1;
        StReq: begin
          WRITE_ADDR_VALID = 1'b1;
          WRITE_ADDR       = seg_addr_q;
          WRITE_LEN        = LEN_W'(buf_cnt - CNT_W'(1));
          WRITE_ID         = id_q;
        end
        StDrain: begin
          WRITE_DATA      = buf_head[MEM_DW-1:0];
          WRITE_STRB      = buf_head[BUF_W-1:MEM_DW];
          WRITE_DATA_LAST = (buf_cnt == CNT_W'(1));
        end
        StResp: begin
          SLV_WR_BACK_VALID = 1'b1;
          SLV_WR_BACK_ID    = id_q;
          SLV_WR_BACK_RESP  = (err_q || !incr_q) ? RESP_SLVERR : RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q        <= '0;
      addr_q      <= '0;
      seg_addr_q  <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      incr_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      word_data_q <= '0;
      word_strb_q <= '0;
    end else begin
      if (addr_fire) begin
        id_q        <= SLV_WR_ADDR_ID;
        addr_q      <= SLV_WR_ADDR;
        seg_addr_q  <= SLV_WR_ADDR & ALIGN_MASK;
        len_q       <= SLV_WR_ADDR_LEN;
        beat_q      <= '0;
        incr_q      <= (SLV_WR_ADDR_BURST == BURST_INCR);
        err_q       <= 1'b0;
        done_q      <= 1'b0;
        word_data_q <= '0;
        word_strb_q <= '0;
      end
      if (beat_fire) begin
        addr_q <= addr_q + ADDR_W'(1);
        beat_q <= beat_q + 8'd1;
        // The beat counter decides where the burst ends; LAST only flags disagreement.
        if (SLV_WR_DATA_LAST != is_final) err_q <= 1'b1;
        if (is_final) done_q <= 1'b1;
        if (word_close) begin
          word_data_q <= '0;
          word_strb_q <= '0;
        end else if (incr_q) begin
          word_data_q <= word_data_nx;
          word_strb_q <= word_strb_nx;
        end
      end
      // A segment only closes early on a full buffer, so the next beat is word aligned.
      if (last_pop && !done_q) seg_addr_q <= addr_q & ALIGN_MASK;
    end
  end

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Randomized bench for ddr_wr_packer against a beat-to-lane reference model.
module tb_ddr_wr_packer;
  import ddr_wr_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   SLV_WR_ADDR_ID;
  logic [27:0]  SLV_WR_ADDR;
  logic [7:0]   SLV_WR_ADDR_LEN;
  logic [1:0]   SLV_WR_ADDR_BURST;
  logic         SLV_WR_ADDR_VALID;
  logic         SLV_WR_ADDR_READY;
  logic [31:0]  SLV_WR_DATA;
  logic [3:0]   SLV_WR_STRB;
  logic         SLV_WR_DATA_LAST;
  logic         SLV_WR_DATA_VALID;
  logic         SLV_WR_DATA_READY;
  logic [3:0]   SLV_WR_BACK_ID;
  logic [1:0]   SLV_WR_BACK_RESP;
  logic         SLV_WR_BACK_VALID;
  logic         SLV_WR_BACK_READY;
  logic [27:0]  WRITE_ADDR;
  logic [3:0]   WRITE_LEN;
  logic [3:0]   WRITE_ID;
  logic         WRITE_ADDR_VALID;
  logic         WRITE_ADDR_READY;
  logic [255:0] WRITE_DATA;
  logic [31:0]  WRITE_STRB;
  logic         WRITE_DATA_READY;
  logic         WRITE_DATA_LAST;

  ddr_wr_packer dut (
    .clk              (clk),
    .rst              (rst),
    .SLV_WR_ADDR_ID   (SLV_WR_ADDR_ID),
    .SLV_WR_ADDR      (SLV_WR_ADDR),
    .SLV_WR_ADDR_LEN  (SLV_WR_ADDR_LEN),
    .SLV_WR_ADDR_BURST(SLV_WR_ADDR_BURST),
    .SLV_WR_ADDR_VALID(SLV_WR_ADDR_VALID),
    .SLV_WR_ADDR_READY(SLV_WR_ADDR_READY),
    .SLV_WR_DATA      (SLV_WR_DATA),
    .SLV_WR_STRB      (SLV_WR_STRB),
    .SLV_WR_DATA_LAST (SLV_WR_DATA_LAST),
    .SLV_WR_DATA_VALID(SLV_WR_DATA_VALID),
    .SLV_WR_DATA_READY(SLV_WR_DATA_READY),
    .SLV_WR_BACK_ID   (SLV_WR_BACK_ID),
    .SLV_WR_BACK_RESP (SLV_WR_BACK_RESP),
    .SLV_WR_BACK_VALID(SLV_WR_BACK_VALID),
    .SLV_WR_BACK_READY(SLV_WR_BACK_READY),
    .WRITE_ADDR       (WRITE_ADDR),
    .WRITE_LEN        (WRITE_LEN),
    .WRITE_ID         (WRITE_ID),
    .WRITE_ADDR_VALID (WRITE_ADDR_VALID),
    .WRITE_ADDR_READY (WRITE_ADDR_READY),
    .WRITE_DATA       (WRITE_DATA),
    .WRITE_STRB       (WRITE_STRB),
    .WRITE_DATA_READY (WRITE_DATA_READY),
    .WRITE_DATA_LAST  (WRITE_DATA_LAST)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int aval_cycles = 0;

  always @(posedge clk) if (WRITE_ADDR_VALID === 1'b1) aval_cycles <= aval_cycles + 1;

  // Beat stimulus and expected native words.
  logic [31:0]  b_data [256];
  logic [3:0]   b_strb [256];
  logic         b_last [256];
  logic [255:0] e_data [40];
  logic [255:0] e_mask [40];
  logic [31:0]  e_strb [40];
  logic [27:0]  e_seg_addr [4];
  int           e_seg_len [4];
  int           e_nseg;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{SLV_WR_ADDR_READY, SLV_WR_DATA_READY, SLV_WR_BACK_ID, SLV_WR_BACK_RESP,
             SLV_WR_BACK_VALID, WRITE_ADDR, WRITE_LEN, WRITE_ID, WRITE_ADDR_VALID,
             WRITE_DATA, WRITE_STRB, WRITE_DATA_LAST};
  endfunction

  // Beat k of the burst sits at slave word addr+k, i.e. lane (addr+k)%8 of word (off+k)/8.
  task automatic build_model(input logic [27:0] addr, input int len, input bit incr);
    int off, nwords, j, ln;
    off = int'(addr[2:0]);
    nwords = incr ? (off + len + 1 + 7) / 8 : 0;
    for (int i = 0; i < 40; i++) begin
      e_data[i] = '0;
      e_mask[i] = '0;
      e_strb[i] = '0;
    end
    for (int k = 0; k <= len; k++) begin
      j  = (off + k) / 8;
      ln = (off + k) % 8;
      e_data[j][ln*32 +: 32] = b_data[k];
      e_mask[j][ln*32 +: 32] = 32'hffff_ffff;
      e_strb[j][ln*4 +: 4]   = b_strb[k];
    end
    e_nseg = (nwords + 15) / 16;
    for (int s = 0; s < e_nseg; s++) begin
      e_seg_addr[s] = 28'((addr & ~28'h7) + 28'(s * 128));
      e_seg_len[s]  = ((nwords - 16 * s) > 16 ? 16 : (nwords - 16 * s)) - 1;
    end
  endtask

  task automatic drive_slave(input logic [3:0] id, input logic [27:0] addr, input int len,
                             input logic [1:0] burst);
    int to;
    SLV_WR_ADDR_ID    = id;
    SLV_WR_ADDR       = addr;
    SLV_WR_ADDR_LEN   = 8'(len);
    SLV_WR_ADDR_BURST = burst;
    SLV_WR_ADDR_VALID = 1'b1;
    to = 0;
    while (SLV_WR_ADDR_READY !== 1'b1 && to < 200) begin @(negedge clk); to++; end
    check("addr_ready", SLV_WR_ADDR_READY, 1'b1);
    @(negedge clk);
    SLV_WR_ADDR_VALID = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        SLV_WR_DATA_VALID = 1'b0;
        @(negedge clk);
      end
      SLV_WR_DATA       = b_data[k];
      SLV_WR_STRB       = b_strb[k];
      SLV_WR_DATA_LAST  = b_last[k];
      SLV_WR_DATA_VALID = 1'b1;
      to = 0;
      while (SLV_WR_DATA_READY !== 1'b1 && to < 2000) begin @(negedge clk); to++; end
      check("data_ready", SLV_WR_DATA_READY, 1'b1);
      @(negedge clk);
    end
    SLV_WR_DATA_VALID = 1'b0;
    SLV_WR_DATA_LAST  = 1'b0;
  endtask

  task automatic sink(input logic [3:0] id, input int stall_pct);
    int to, w, i;
    w = 0;
    for (int s = 0; s < e_nseg; s++) begin
      to = 0;
      // Random READY pulses before the request must be ignored by the DUT.
      while (WRITE_ADDR_VALID !== 1'b1 && to < 2000) begin
        WRITE_DATA_READY = 1'($urandom);
        @(negedge clk);
        to++;
      end
      WRITE_DATA_READY = 1'b0;
      check("aw_valid", WRITE_ADDR_VALID, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("aw_hold", WRITE_ADDR_VALID, 1'b1);
      end
      check("aw_addr", WRITE_ADDR, e_seg_addr[s]);
      check("aw_len", WRITE_LEN, e_seg_len[s]);
      check("aw_id", WRITE_ID, id);
      WRITE_ADDR_READY = 1'b1;
      @(negedge clk);
      WRITE_ADDR_READY = 1'b0;
      i = 0;
      while (i <= e_seg_len[s]) begin
        if ($urandom_range(0, 99) < stall_pct) begin
          WRITE_DATA_READY = 1'b0;
          @(negedge clk);
        end else begin
          WRITE_DATA_READY = 1'b1;
          check("w_data", WRITE_DATA & e_mask[w], e_data[w]);
          check("w_strb", WRITE_STRB, e_strb[w]);
          check("w_last", WRITE_DATA_LAST, i == e_seg_len[s]);
          @(negedge clk);
          i++;
          w++;
        end
      end
      WRITE_DATA_READY = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [3:0] id, input logic [27:0] addr, input int len,
                         input logic [1:0] burst, input bit full_strb, input int early_last,
                         input int resp_delay, input int stall_pct);
    bit incr, exp_err;
    int av0, to;
    incr = (burst == BURST_INCR);
    for (int k = 0; k <= len; k++) begin
      b_data[k] = $urandom;
      b_strb[k] = full_strb ? 4'hf : 4'($urandom);
      b_last[k] = (k == len);
    end
    exp_err = !incr;
    if (early_last >= 0 && early_last != len) begin
      b_last[early_last] = 1'b1;
      b_last[len]        = 1'b0;
      exp_err            = 1'b1;
    end
    build_model(addr, len, incr);
    av0 = aval_cycles;
    fork
      drive_slave(id, addr, len, burst);
      sink(id, stall_pct);
    join
    if (!incr) check("no_native_req", 32'(aval_cycles - av0), 32'd0);
    to = 0;
    while (SLV_WR_BACK_VALID !== 1'b1 && to < 2000) begin @(negedge clk); to++; end
    check("b_valid", SLV_WR_BACK_VALID, 1'b1);
    for (int d = 0; d < resp_delay; d++) begin
      check("b_hold", SLV_WR_BACK_VALID, 1'b1);
      check("b_hold_resp", SLV_WR_BACK_RESP, exp_err ? RESP_SLVERR : RESP_OKAY);
      @(negedge clk);
    end
    check("b_id", SLV_WR_BACK_ID, id);
    check("b_resp", SLV_WR_BACK_RESP, exp_err ? RESP_SLVERR : RESP_OKAY);
    SLV_WR_BACK_READY = 1'b1;
    @(negedge clk);
    SLV_WR_BACK_READY = 1'b0;
    check("b_done", SLV_WR_BACK_VALID, 1'b0);
  endtask

  initial begin
    int to, av0, r, l, el;
    logic [27:0] a;
    logic [1:0]  b;
    rst = 1'b1;
    SLV_WR_ADDR_ID = '0;  SLV_WR_ADDR = '0;  SLV_WR_ADDR_LEN = '0;  SLV_WR_ADDR_BURST = '0;
    SLV_WR_ADDR_VALID = 1'b0;  SLV_WR_DATA = '0;  SLV_WR_STRB = '0;  SLV_WR_DATA_LAST = 1'b0;
    SLV_WR_DATA_VALID = 1'b0;  SLV_WR_BACK_READY = 1'b0;  WRITE_ADDR_READY = 1'b0;
    WRITE_DATA_READY = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outs", any_out(), 1'b0);
    check("rst_addr_ready", SLV_WR_ADDR_READY, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_addr_ready", SLV_WR_ADDR_READY, 1'b1);

    run_txn(4'h1, 28'h0, 7, BURST_INCR, 1'b1, -1, 0, 0);          // single full word
    run_txn(4'h2, 28'h3, 7, BURST_INCR, 1'b1, -1, 1, 20);         // straddles two words
    run_txn(4'h6, 28'h0, 255, BURST_INCR, 1'b0, -1, 0, 10);       // two 16-word segments
    run_txn(4'hA, 28'h40, 3, BURST_WRAP, 1'b1, -1, 2, 0);         // unsupported burst
    run_txn(4'h5, 28'h20, 4, BURST_INCR, 1'b0, 2, 5, 50);         // early LAST, slow sink
    run_txn(4'hC, 28'hFFFFFC0, 200, BURST_INCR, 1'b0, -1, 1, 15); // segment address wraps

    for (int t = 0; t < 12; t++) begin
      a  = ($urandom_range(0, 3) == 0) ? 28'hFFFFFFF - 28'($urandom_range(0, 40))
                                       : 28'($urandom);
      l  = ($urandom_range(0, 4) == 0) ? $urandom_range(41, 255) : $urandom_range(0, 40);
      r  = $urandom_range(0, 9);
      b  = (r == 0) ? BURST_FIXED : (r == 1) ? BURST_WRAP : (r == 2) ? 2'b11 : BURST_INCR;
      el = ($urandom_range(0, 7) == 0) ? $urandom_range(0, l) : -1;
      run_txn(4'($urandom), a, l, b, 1'($urandom), el, $urandom_range(0, 3),
              $urandom_range(0, 50));
    end

    // Reset while draining the first segment of a long burst.
    SLV_WR_ADDR_ID = 4'h9;  SLV_WR_ADDR = 28'h0;  SLV_WR_ADDR_LEN = 8'd255;
    SLV_WR_ADDR_BURST = BURST_INCR;  SLV_WR_ADDR_VALID = 1'b1;
    to = 0;
    while (SLV_WR_ADDR_READY !== 1'b1 && to < 200) begin @(negedge clk); to++; end
    check("rd_addr_ready", SLV_WR_ADDR_READY, 1'b1);
    @(negedge clk);
    SLV_WR_ADDR_VALID = 1'b0;
    for (int k = 0; k < 128; k++) begin
      SLV_WR_DATA = $urandom;  SLV_WR_STRB = 4'hf;  SLV_WR_DATA_LAST = 1'b0;
      SLV_WR_DATA_VALID = 1'b1;
      to = 0;
      while (SLV_WR_DATA_READY !== 1'b1 && to < 200) begin @(negedge clk); to++; end
      @(negedge clk);
    end
    SLV_WR_DATA_VALID = 1'b0;
    to = 0;
    while (WRITE_ADDR_VALID !== 1'b1 && to < 200) begin @(negedge clk); to++; end
    check("rd_aw_valid", WRITE_ADDR_VALID, 1'b1);
    check("rd_aw_len", WRITE_LEN, 4'd15);
    WRITE_ADDR_READY = 1'b1;
    @(negedge clk);
    WRITE_ADDR_READY = 1'b0;
    WRITE_DATA_READY = 1'b1;
    repeat (3) @(negedge clk);
    WRITE_DATA_READY = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst_drain_outs", any_out(), 1'b0);
    check("rst_drain_ardy", SLV_WR_ADDR_READY, 1'b0);
    rst = 1'b0;
    av0 = aval_cycles;
    @(negedge clk);
    check("rst_drain_idle", SLV_WR_ADDR_READY, 1'b1);
    WRITE_DATA_READY = 1'b1;
    repeat (4) @(negedge clk);
    WRITE_DATA_READY = 1'b0;
    check("rst_no_native", 32'(aval_cycles - av0), 32'd0);
    run_txn(4'h3, 28'h10, 0, BURST_INCR, 1'b1, -1, 2, 20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_wr_packer.md
DDR_WR_PACKER -- requirements
Module: ddr_wr_packer

Interface
REQ-001 Parameter SLV_DW, 32, slave data width in bits.
REQ-002 Parameter MEM_DW, 256, native DDR data width; MEM_DW/SLV_DW = RATIO, a power of two >=2.
REQ-003 Parameter ADDR_W, 28, address width in SLV_DW-word units, both sides.
REQ-004 Parameter ID_W, 4, transaction ID width.
REQ-005 Parameter MAX_WORDS, 16, max native burst length in MEM_DW words; also the segment buffer depth.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 Ports: clk in 1, clock; rst in 1, sync active-high reset.
REQ-008 SLV_WR_ADDR_ID in ID_W; SLV_WR_ADDR in ADDR_W; SLV_WR_ADDR_LEN in 8 (beats-1); SLV_WR_ADDR_BURST in 2; SLV_WR_ADDR_VALID in 1; SLV_WR_ADDR_READY out 1.
REQ-009 SLV_WR_DATA in SLV_DW; SLV_WR_STRB in SLV_DW/8; SLV_WR_DATA_LAST in 1; SLV_WR_DATA_VALID in 1; SLV_WR_DATA_READY out 1.
REQ-010 SLV_WR_BACK_ID out ID_W; SLV_WR_BACK_RESP out 2; SLV_WR_BACK_VALID out 1; SLV_WR_BACK_READY in 1.
REQ-011 WRITE_ADDR out ADDR_W; WRITE_LEN out log2(MAX_WORDS) (words-1); WRITE_ID out ID_W; WRITE_ADDR_VALID out 1; WRITE_ADDR_READY in 1.
REQ-012 WRITE_DATA out MEM_DW; WRITE_STRB out MEM_DW/8; WRITE_DATA_READY in 1 (pull, no valid); WRITE_DATA_LAST out 1.

Function
REQ-013 FSM states IDLE, FILL, REQ, DRAIN, RESP; only one slave transaction in flight.
REQ-014 IDLE: SLV_WR_ADDR_READY=1; on handshake latch ID, ADDR, LEN, BURST; go FILL next cycle.
REQ-015 BURST=01 (INCR) is packed; BURST 00/10/11 consumes all LEN+1 beats, writes nothing, responds SLVERR (2'b10).
REQ-016 FILL: SLV_WR_DATA_READY=1; beat k lands in lane (ADDR+k) mod RATIO of current wide word; unfilled lanes carry strobe 0.
REQ-017 Wide word closes when its top lane fills or the final beat (beat LEN) is accepted; closed word is written to the segment buffer same cycle.
REQ-018 Segment closes when buffer holds MAX_WORDS words or final beat accepted; FILL->REQ; SLV_WR_DATA_READY=0 outside FILL.
REQ-019 REQ: WRITE_ADDR = segment start address with low log2(RATIO) bits zero; WRITE_LEN = words-1; WRITE_ID = latched ID; VALID held stable until READY; then DRAIN.
REQ-020 DRAIN: WRITE_DATA/STRB present buffer head combinationally; each WRITE_DATA_READY cycle pops one word; WRITE_DATA_LAST=1 with the final segment word.
REQ-021 After last pop: more beats remain -> FILL; else -> RESP.
REQ-022 RESP: SLV_WR_BACK_VALID=1, BACK_ID=latched ID, RESP OKAY (00) or SLVERR (10); held until READY, then IDLE.
REQ-023 Beat counter is authoritative: SLV_WR_DATA_LAST on a beat other than LEN, or absent on beat LEN, sets sticky SLVERR; data still written.
REQ-024 Address arithmetic wraps modulo 2^ADDR_W; no boundary splitting other than MAX_WORDS.
REQ-025 WRITE_DATA_READY outside DRAIN is ignored; buffer never underflows or overflows.

Reset
REQ-026 rst clears FSM to IDLE, counters and buffer pointers to 0, sticky error to 0.
REQ-027 During rst all outputs are 0 except SLV_WR_ADDR_READY, which is 0 in the reset cycle and 1 the cycle after.
REQ-028 rst mid-transaction discards buffered data and the pending response; no native handshake completes afterwards.

Structure
REQ-029 Package ddr_wr_pkg holds RESP_OKAY/RESP_SLVERR, BURST_FIXED/INCR/WRAP constants and the state enum.
REQ-030 Segment buffer is sub-module ddr_wr_seg_buf (MAX_WORDS x (MEM_DW+MEM_DW/8), push/pop/count).

Verification
REQ-031 ADDR=0, LEN=7, INCR, strobes all 1 -> one native burst ADDR 0, LEN 0, STRB all ones, LAST=1; RESP OKAY.
REQ-032 ADDR=3, LEN=7 -> two words at ADDR 0: word0 STRB lanes 3-7 set, word1 lanes 0-2 set; WRITE_LEN=1.
REQ-033 ADDR=0, LEN=255 -> two native bursts of 16 words (WRITE_ADDR 0, 128), one OKAY response.
REQ-034 BURST=10, LEN=3 -> 4 beats accepted, no WRITE_ADDR_VALID, RESP SLVERR with latched ID.
REQ-035 LAST asserted on beat 2 of LEN=4, WRITE_DATA_READY stalled random cycles, BACK_READY delayed 5 -> data intact, RESP SLVERR held 5 cycles.
REQ-036 rst asserted during DRAIN -> all outputs 0 next cycle, IDLE; fresh LEN=0 write completes OKAY.
